fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_npc_calc.sv | 26 ++
 rtl/fetch_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants: next-PC select encodings and fetch address map defaults.
package fetch_unit_pkg;

  // Next-PC select coming from the decode stage
  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,  // PC + 4
    NPC_BR  = 2'b01,  // conditional PC-relative branch
    NPC_J   = 2'b10,  // j / jal, pseudo-direct target
    NPC_JR  = 2'b11   // jr, register target
  } npc_op_e;

  localparam logic [31:0] PC_RESET_DFLT = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DFLT  = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DFLT = 4096;

  // Branch displacement: sign-extended 16-bit word offset scaled to bytes
  function automatic logic [31:0] branch_disp(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC selection for the fetch stage.
module npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  npc_op,
  input  logic        d_cmp,
  input  logic [25:0] d_imm26,
  input  logic [31:0] d_pc_plus4,
  input  logic [31:0] d_reg_rs,
  output logic [31:0] npc
);

  // Pick the next PC; a not-taken branch falls through to the fetch-stage PC+4
  always_comb begin
    npc = pc_plus4;
    case (npc_op_e'(npc_op))
      NPC_SEQ: npc = pc_plus4;
      NPC_BR:  npc = d_cmp ? (d_pc_plus4 + branch_disp(d_imm26[15:0])) : pc_plus4;
      NPC_J:   npc = {d_pc_plus4[31:28], d_imm26, 2'b00};
      NPC_JR:  npc = d_reg_rs;
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, instruction address fault check and fetch counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DFLT,
  parameter logic [31:0] IM_BASE  = IM_BASE_DFLT,
  parameter int unsigned IM_WORDS = IM_WORDS_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        D_cmp,
  input  logic [25:0] D_Imm26,
  input  logic [31:0] D_PCPlus4,
  input  logic [31:0] D_RegRs,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_Ins,
  output logic [31:0] F_PCAddr,
  output logic [31:0] F_PCPlus4,
  output logic        F_AdEL,
  output logic [31:0] fetch_cnt
);

  // One past the last legal byte address, kept in 33 bits so the limit cannot wrap
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic        adel;

  assign pc_plus4 = pc_q + 32'd4;

  npc_calc u_npc_calc (
    .pc_plus4   (pc_plus4),
    .npc_op     (npc_op),
    .d_cmp      (D_cmp),
    .d_imm26    (D_Imm26),
    .d_pc_plus4 (D_PCPlus4),
    .d_reg_rs   (D_RegRs),
    .npc        (npc)
  );

  // Advance PC and count the cycle only when the pipeline is not frozen
  always_comb begin
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    if (!stall) begin
      pc_d        = npc;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // State registers; reset forces the PC and counter immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= PC_RESET;
      fetch_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Misaligned or outside the instruction window raises the fetch fault
  always_comb begin
    adel = (pc_q[1:0] != 2'b00)
        || ({1'b0, pc_q} < {1'b0, IM_BASE})
        || ({1'b0, pc_q} >= IM_LIMIT);
  end

  assign i_inst_addr = pc_q;
  assign F_PCAddr    = pc_q;
  assign F_PCPlus4   = pc_plus4;
  assign F_AdEL      = adel;
  assign F_Ins       = adel ? 32'h0000_0000 : i_inst_rdata;
  assign fetch_cnt   = fetch_cnt_q;

endmodule
